// File: rtl/fetch_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : fetch_pkg
// Brief  : Shared types and defaults for the instruction-fetch sequencer.
//          Holds the fetch FSM state encoding, the next-PC select encoding
//          and the default address/word widths of the 9-bit ISA.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
package fetch_pkg;

  localparam int A_DEF = 12;  // instruction address width
  localparam int W_DEF = 9;   // instruction word width

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  // Next-PC source select
  typedef enum logic [1:0] {
    NPC_INC = 2'd0,  // PC + 1
    NPC_ABS = 2'd1,  // Target
    NPC_REL = 2'd2   // IrPc + signed Target
  } npc_sel_t;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_ctrl_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : fetch_ctrl_if
// Brief  : Bus between the fetch sequencer, the instruction ROM and the
//          decode/control unit.
//          slave  : the fetch sequencer (fetch_ctrl)
//          master : the surrounding CPU / testbench
// Ports  : Start, Stall, BranchEn, BranchRel, Target, HaltReq, InstIn  (to fetch)
//          InstAddress, Inst, IrPc, InstValid, Done                   (from fetch)
//          CycleCnt, InstCnt  (from fetch, only with FETCH_PERF_EN)
// Macro  : FETCH_PERF_EN adds the performance-counter signals.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
interface fetch_ctrl_if #(
  parameter int A    = fetch_pkg::A_DEF,
  parameter int W    = fetch_pkg::W_DEF
`ifdef FETCH_PERF_EN
  ,
  parameter int CNTW = 16
`endif
) ();

  logic         Start;
  logic         Stall;
  logic         BranchEn;
  logic         BranchRel;
  logic [A-1:0] Target;
  logic         HaltReq;
  logic [W-1:0] InstIn;
  logic [A-1:0] InstAddress;
  logic [W-1:0] Inst;
  logic [A-1:0] IrPc;
  logic         InstValid;
  logic         Done;
`ifdef FETCH_PERF_EN
  logic [CNTW-1:0] CycleCnt;
  logic [CNTW-1:0] InstCnt;
`endif

  modport slave (
    input  Start, Stall, BranchEn, BranchRel, Target, HaltReq, InstIn,
    output InstAddress, Inst, IrPc, InstValid, Done
`ifdef FETCH_PERF_EN
    ,
    output CycleCnt, InstCnt
`endif
  );

  modport master (
    output Start, Stall, BranchEn, BranchRel, Target, HaltReq, InstIn,
    input  InstAddress, Inst, IrPc, InstValid, Done
`ifdef FETCH_PERF_EN
    ,
    input  CycleCnt, InstCnt
`endif
  );

endinterface : fetch_ctrl_if
`default_nettype wire

// File: rtl/fetch_next_pc.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : fetch_next_pc
// Brief  : Combinational next-PC mux. All arithmetic is A-bit modular, so
//          PC wrap-around and relative targets wrap without any flag.
// Ports  : pc     in  A  current fetch address
//          irpc   in  A  address of the instruction in IR (relative base)
//          target in  A  absolute target or two's-complement offset
//          sel    in  2  npc_sel_t source select
//          npc    out A  next fetch address
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
module fetch_next_pc
  import fetch_pkg::*;
#(
  parameter int A = A_DEF
) (
  input  wire logic [A-1:0] pc,
  input  wire logic [A-1:0] irpc,
  input  wire logic [A-1:0] target,
  input  wire npc_sel_t     sel,
  output logic      [A-1:0] npc
);

  always_comb begin
    npc = pc + A'(1);
    case (sel)
      NPC_ABS: npc = target;
      // Unsigned A-bit add of a two's-complement offset is the signed add mod 2**A
      NPC_REL: npc = irpc + target;
      default: npc = pc + A'(1);
    endcase
  end

endmodule : fetch_next_pc
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : fetch_ctrl
// Brief  : Instruction-fetch sequencer. Owns the PC, drives the combinational
//          ROM address, registers the returned word into IR, and handles
//          start/halt, stalls and absolute/relative branches (one-slot squash).
// Ports  : Clk    in  system clock, rising edge
//          Reset  in  asynchronous active-high reset
//          bus    fetch_ctrl_if.slave (see interface header for signals)
// Macro  : FETCH_PERF_EN adds saturating CycleCnt / InstCnt counters.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int          A        = A_DEF,
  parameter int          W        = W_DEF,
  parameter int unsigned RESET_PC = 0
`ifdef FETCH_PERF_EN
  ,
  parameter int          CNTW     = 16
`endif
) (
  input wire logic     Clk,
  input wire logic     Reset,
  fetch_ctrl_if.slave  bus
);

  localparam logic [1:0]   c_ST_IDLE   = 2'(IDLE);
  localparam logic [1:0]   c_ST_RUN    = 2'(RUN);
  localparam logic [1:0]   c_ST_HALTED = 2'(HALTED);
  localparam logic [A-1:0] c_RESET_PC  = A'(RESET_PC);

  logic [1:0]   r_state;
  logic [A-1:0] r_pc;
  logic [W-1:0] r_inst;
  logic [A-1:0] r_irpc;
  logic         r_valid;
  logic         r_done;

  logic         w_advance;
  logic         w_halt;
  logic         w_branch;
  npc_sel_t     w_sel;
  logic [A-1:0] w_npc;

  // Halt/branch requests describe the word in IR, so they only mean
  // something when IR is live and decode is not stalling.
  assign w_advance = (r_state == c_ST_RUN) && !bus.Stall;
  assign w_halt    = w_advance && r_valid && bus.HaltReq;
  assign w_branch  = w_advance && r_valid && bus.BranchEn && !bus.HaltReq;

  always_comb begin
    w_sel = NPC_INC;
    if (w_branch) w_sel = bus.BranchRel ? NPC_REL : NPC_ABS;
  end

  fetch_next_pc #(
    .A (A)
  ) u_next_pc (
    .pc     (r_pc),
    .irpc   (r_irpc),
    .target (bus.Target),
    .sel    (w_sel),
    .npc    (w_npc)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= c_ST_IDLE;
      r_pc    <= c_RESET_PC;
      r_inst  <= '0;
      r_irpc  <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        c_ST_IDLE, c_ST_HALTED: begin
          if (bus.Start) begin
            r_state <= c_ST_RUN;
            r_pc    <= c_RESET_PC;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
          end
        end
        c_ST_RUN: begin
          if (w_halt) begin
            r_state <= c_ST_HALTED;
            r_done  <= 1'b1;
            r_valid <= 1'b0;
          end else if (w_branch) begin
            // Word fetched this cycle is from the fall-through path: drop it
            r_pc    <= w_npc;
            r_valid <= 1'b0;
          end else if (w_advance) begin
            r_inst  <= bus.InstIn;
            r_irpc  <= r_pc;
            r_valid <= 1'b1;
            r_pc    <= w_npc;
          end
        end
        default: r_state <= c_ST_IDLE;
      endcase
    end
  end

  assign bus.InstAddress = r_pc;
  assign bus.Inst        = r_inst;
  assign bus.IrPc        = r_irpc;
  assign bus.InstValid   = r_valid;
  assign bus.Done        = r_done;

`ifdef FETCH_PERF_EN
  logic [CNTW-1:0] r_cycle_cnt;
  logic [CNTW-1:0] r_inst_cnt;
  logic            w_start;
  logic            w_inst_retire;

  assign w_start       = (r_state != c_ST_RUN) && bus.Start;
  assign w_inst_retire = w_advance && r_valid && !bus.HaltReq;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_cycle_cnt <= '0;
      r_inst_cnt  <= '0;
    end else if (w_start) begin
      r_cycle_cnt <= '0;
      r_inst_cnt  <= '0;
    end else begin
      if ((r_state == c_ST_RUN) && (r_cycle_cnt != '1))
        r_cycle_cnt <= r_cycle_cnt + 1'b1;
      if (w_inst_retire && (r_inst_cnt != '1))
        r_inst_cnt <= r_inst_cnt + 1'b1;
    end
  end

  assign bus.CycleCnt = r_cycle_cnt;
  assign bus.InstCnt  = r_inst_cnt;
`endif

endmodule : fetch_ctrl
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : tb_fetch_ctrl
// Brief  : Directed self-checking bench for fetch_ctrl with a combinational
//          ROM model.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
module tb_fetch_ctrl;

  localparam int A = 12;
  localparam int W = 9;

  logic Clk;
  logic Reset;
  int   vecs;
  int   fails;

`ifdef FETCH_PERF_EN
  fetch_ctrl_if #(.A(A), .W(W), .CNTW(16)) bus ();
  fetch_ctrl #(.A(A), .W(W), .RESET_PC(0), .CNTW(16)) dut (
    .Clk (Clk), .Reset (Reset), .bus (bus.slave));
`else
  fetch_ctrl_if #(.A(A), .W(W)) bus ();
  fetch_ctrl #(.A(A), .W(W), .RESET_PC(0)) dut (
    .Clk (Clk), .Reset (Reset), .bus (bus.slave));
`endif

  function automatic logic [W-1:0] rom(input logic [A-1:0] a);
    return a[W-1:0] ^ 9'h155;
  endfunction

  assign bus.InstIn = rom(bus.InstAddress);

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic branch(input logic rel, input logic [A-1:0] tgt);
    bus.BranchEn  = 1'b1;
    bus.BranchRel = rel;
    bus.Target    = tgt;
    tick();
    bus.BranchEn  = 1'b0;
    bus.BranchRel = 1'b0;
    bus.Target    = '0;
  endtask

  initial begin
    vecs = 0;
    fails = 0;
    Reset = 1'b1;
    bus.Start = 1'b0; bus.Stall = 1'b0; bus.BranchEn = 1'b0;
    bus.BranchRel = 1'b0; bus.Target = '0; bus.HaltReq = 1'b0;
    #1;
    chk("rst_valid", 32'(bus.InstValid), 0);
    chk("rst_done",  32'(bus.Done), 0);
    chk("rst_inst",  32'(bus.Inst), 0);
    chk("rst_irpc",  32'(bus.IrPc), 0);
    chk("rst_addr",  32'(bus.InstAddress), 0);
    tick(); tick();
    Reset = 1'b0;
    tick();
    chk("idle_valid", 32'(bus.InstValid), 0);

    // Start and sequential fetch
    bus.Start = 1'b1; tick(); bus.Start = 1'b0;
    chk("start_valid", 32'(bus.InstValid), 0);
    chk("start_addr",  32'(bus.InstAddress), 0);
    tick();
    chk("seq0_valid", 32'(bus.InstValid), 1);
    chk("seq0_irpc",  32'(bus.IrPc), 0);
    chk("seq0_inst",  32'(bus.Inst), 32'h155);
    chk("seq0_addr",  32'(bus.InstAddress), 1);
    tick();
    chk("seq1_irpc", 32'(bus.IrPc), 1);
    chk("seq1_inst", 32'(bus.Inst), 32'h154);
    tick();
    chk("seq2_irpc", 32'(bus.IrPc), 2);
    chk("seq2_inst", 32'(bus.Inst), 32'h157);

    // Stall for 3 cycles at IrPc=2
    bus.Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_irpc",  32'(bus.IrPc), 2);
      chk("stall_addr",  32'(bus.InstAddress), 3);
      chk("stall_valid", 32'(bus.InstValid), 1);
    end
    // Branch request while stalled must be ignored
    bus.Stall = 1'b1; bus.BranchEn = 1'b1; bus.Target = 12'd100;
    tick();
    chk("stall_br_addr", 32'(bus.InstAddress), 3);
    bus.Stall = 1'b0; bus.BranchEn = 1'b0; bus.Target = '0;
    tick();
    chk("resume_irpc", 32'(bus.IrPc), 3);
    chk("resume_inst", 32'(bus.Inst), 32'h156);
    tick();
    tick();
    chk("seq5_irpc", 32'(bus.IrPc), 5);

    // Absolute branch to 20
    branch(1'b0, 12'd20);
    chk("babs_valid", 32'(bus.InstValid), 0);
    chk("babs_irpc",  32'(bus.IrPc), 5);
    chk("babs_addr",  32'(bus.InstAddress), 20);
    tick();
    chk("babs_tgt_irpc",  32'(bus.IrPc), 20);
    chk("babs_tgt_valid", 32'(bus.InstValid), 1);
    chk("babs_tgt_inst",  32'(bus.Inst), 32'h141);
    tick();
    chk("seq21_irpc", 32'(bus.IrPc), 21);

    // Relative branch -3 from 21
    branch(1'b1, 12'hFFD);
    chk("brel_valid", 32'(bus.InstValid), 0);
    chk("brel_addr",  32'(bus.InstAddress), 18);
    tick();
    chk("brel_tgt_irpc", 32'(bus.IrPc), 18);

    // Go to 4 and halt there
    branch(1'b0, 12'd4);
    tick();
    chk("pre_halt_irpc", 32'(bus.IrPc), 4);
    bus.HaltReq = 1'b1; tick(); bus.HaltReq = 1'b0;
    chk("halt_done",  32'(bus.Done), 1);
    chk("halt_valid", 32'(bus.InstValid), 0);
    chk("halt_addr",  32'(bus.InstAddress), 5);
    for (int i = 0; i < 10; i++) begin
      bus.BranchEn = 1'b1; bus.Target = 12'd77;
      tick();
      chk("halted_done",  32'(bus.Done), 1);
      chk("halted_valid", 32'(bus.InstValid), 0);
      chk("halted_addr",  32'(bus.InstAddress), 5);
    end
    bus.BranchEn = 1'b0; bus.Target = '0;

    // Restart; HaltReq while InstValid=0 is ignored
    bus.Start = 1'b1; tick(); bus.Start = 1'b0;
    chk("restart_done",  32'(bus.Done), 0);
    chk("restart_valid", 32'(bus.InstValid), 0);
    chk("restart_addr",  32'(bus.InstAddress), 0);
    bus.HaltReq = 1'b1; tick(); bus.HaltReq = 1'b0;
    chk("halt_ign_done",  32'(bus.Done), 0);
    chk("halt_ign_valid", 32'(bus.InstValid), 1);
    chk("halt_ign_irpc",  32'(bus.IrPc), 0);

    // Start in RUN is ignored
    bus.Start = 1'b1; tick(); bus.Start = 1'b0;
    chk("start_in_run_irpc", 32'(bus.IrPc), 1);

    // PC wrap: absolute to 4095 then sequential
    branch(1'b0, 12'hFFF);
    chk("wrap_br_addr", 32'(bus.InstAddress), 32'hFFF);
    tick();
    chk("wrap_irpc_top", 32'(bus.IrPc), 32'hFFF);
    chk("wrap_addr",     32'(bus.InstAddress), 0);
    tick();
    chk("wrap_irpc_0", 32'(bus.IrPc), 0);
    chk("wrap_inst_0", 32'(bus.Inst), 32'h155);
    // Relative -1 from IrPc 0 wraps to 4095
    branch(1'b1, 12'hFFF);
    chk("rel_wrap_addr", 32'(bus.InstAddress), 32'hFFF);
    tick();
    chk("rel_wrap_irpc", 32'(bus.IrPc), 32'hFFF);

    // HaltReq beats BranchEn
    bus.HaltReq = 1'b1; bus.BranchEn = 1'b1; bus.Target = 12'd9;
    tick();
    bus.HaltReq = 1'b0; bus.BranchEn = 1'b0; bus.Target = '0;
    chk("prio_done", 32'(bus.Done), 1);
    chk("prio_addr", 32'(bus.InstAddress), 0);

    // Reset mid-run takes effect before the next edge
    bus.Start = 1'b1; tick(); bus.Start = 1'b0;
    tick(); tick();
    chk("prerst_valid", 32'(bus.InstValid), 1);
    #2 Reset = 1'b1;
    #1;
    chk("async_rst_valid", 32'(bus.InstValid), 0);
    chk("async_rst_irpc",  32'(bus.IrPc), 0);
    chk("async_rst_inst",  32'(bus.Inst), 0);
    chk("async_rst_addr",  32'(bus.InstAddress), 0);
    chk("async_rst_done",  32'(bus.Done), 0);

    // Start together with Reset: Reset wins, FSM stays idle
    bus.Start = 1'b1; tick(); bus.Start = 1'b0;
    Reset = 1'b0;
    tick(); tick();
    chk("rst_start_valid", 32'(bus.InstValid), 0);
    chk("rst_start_addr",  32'(bus.InstAddress), 0);

`ifdef FETCH_PERF_EN
    // 5 instructions, 2 stall cycles, halt
    bus.Start = 1'b1; tick(); bus.Start = 1'b0;
    chk("perf_clr_cyc",  32'(bus.CycleCnt), 0);
    chk("perf_clr_inst", 32'(bus.InstCnt), 0);
    tick();
    bus.Stall = 1'b1; tick(); tick(); bus.Stall = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("perf_pre_halt_irpc", 32'(bus.IrPc), 5);
    bus.HaltReq = 1'b1; tick(); bus.HaltReq = 1'b0;
    chk("perf_inst", 32'(bus.InstCnt), 5);
    chk("perf_cyc",  32'(bus.CycleCnt), 9);
    tick(); tick();
    chk("perf_hold_inst", 32'(bus.InstCnt), 5);
    chk("perf_hold_cyc",  32'(bus.CycleCnt), 9);
    bus.Start = 1'b1; tick(); bus.Start = 1'b0;
    chk("perf_restart_inst", 32'(bus.InstCnt), 0);
    chk("perf_restart_cyc",  32'(bus.CycleCnt), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule : tb_fetch_ctrl
`default_nettype wire

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Instruction-fetch sequencer for the 9-bit ISA. It owns the program counter and drives InstAddress into the combinational instruction ROM.
- Registers the returned word into an instruction register for decode.
- Handles start/halt handshake with the testbench, stalls, and absolute/relative branches with a one-slot squash.
- Sits between the instruction ROM and the decode/control unit in the top-level CPU.

Parameters:
A, 12, instruction address width (matches ROM depth 2**A)
W, 9, instruction word width
RESET_PC, 0, address fetched first after Start
CNTW, 16, width of performance counters (optional feature only)

Ports:
Clk  in  1  system clock, all state on rising edge
Reset  in  1  asynchronous, active-high reset
Start  in  1  one-cycle pulse; begins execution from RESET_PC
Stall  in  1  decode/datapath not ready; freeze fetch state
BranchEn  in  1  instruction in IR is a taken branch; valid only when InstValid=1
BranchRel  in  1  1: Target is signed offset from IrPc; 0: Target is absolute address
Target  in  A  branch target or two's-complement offset
HaltReq  in  1  instruction in IR is halt; valid only when InstValid=1
InstIn  in  W  ROM data for InstAddress (combinational ROM, same cycle)
InstAddress  out  A  PC presented to ROM
Inst  out  W  instruction register to decode
IrPc  out  A  address of the instruction in Inst
InstValid  out  1  Inst holds a live instruction this cycle
Done  out  1  processor halted; held until next Start

Behaviour:
- Reset (async): state=IDLE, PC=RESET_PC, Inst=0, IrPc=0, InstValid=0, Done=0. Reset mid-run aborts immediately; no partial update survives.
- States: IDLE, RUN, HALTED.
- IDLE/HALTED + Start:
  - PC<=RESET_PC, InstValid<=0, Done<=0, go to RUN.
  - Start while in RUN is ignored.
- RUN, Stall=1:
  - PC, Inst, IrPc, InstValid hold.
  - BranchEn and HaltReq are not acted on; decode holds them until Stall drops.
- RUN, Stall=0, priority HaltReq > BranchEn > sequential. HaltReq and BranchEn are qualified by InstValid.
  - Halt: go to HALTED, Done<=1, InstValid<=0, PC holds.
  - Branch:
    - PC<=Target when BranchRel=0.
    - PC<=IrPc+Target (A-bit modular, Target sign-interpreted) when BranchRel=1.
    - InstValid<=0; the word fetched this cycle is squashed, so there is one bubble.
    - Inst/IrPc hold.
  - Sequential: Inst<=InstIn, IrPc<=PC, InstValid<=1, PC<=PC+1.
- Latency:
  - First valid instruction appears 1 cycle after entering RUN.
  - Taken branch target is valid in Inst 2 cycles after the branch cycle.
- Wrap-around: PC=2**A-1 increments to 0; relative targets wrap modulo 2**A. No error is flagged.
- Start and Reset together: Reset wins.
- HaltReq with InstValid=0: ignored.
- Done and InstValid are never 1 in the same cycle.
- In HALTED, InstAddress=PC (frozen) and no further state change occurs until Start.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined:
  - Adds outputs CycleCnt[CNTW-1:0] (cycles spent in RUN) and InstCnt[CNTW-1:0] (cycles with InstValid=1, Stall=0, HaltReq=0).
  - Both counters clear on Reset and on Start, and saturate at all-ones.
  - Both hold in HALTED.
- Undefined: ports and counters are absent; the rest of the behaviour is identical.

Decomposition:
- Package fetch_pkg: typedef enum logic[1:0] fetch_state_t {IDLE, RUN, HALTED}; default widths A_DEF=12, W_DEF=9.
- Sub-module fetch_next_pc: combinational next-PC mux (increment / absolute / relative, modular add). Instantiated once; unit-testable standalone.

Test Plan:
- Reset, Start, ROM words 0..3, no stall → InstValid rises 1 cycle after Start; IrPc=0,1,2,3 on consecutive cycles; Inst matches ROM.
- Stall=1 for 3 cycles at IrPc=2 → Inst/IrPc/PC frozen; resumes IrPc=3 the cycle after Stall drops.
- BranchEn at IrPc=5, BranchRel=0, Target=20 → next cycle InstValid=0; following cycle IrPc=20. Then BranchRel=1, Target=-3 (all-ones minus 2) at IrPc=21 → IrPc=18.
- HaltReq at IrPc=4 → Done=1 next cycle, InstValid=0, held for 10 cycles. Start → Done=0, IrPc=0 fetched again.
- PC wrap: absolute branch to 4095, then sequential → IrPc=4095 then 0. Reset asserted mid-run → all outputs at reset values immediately, before the next edge.
- FETCH_PERF_EN: 5 instructions, 2 stall cycles, then halt → InstCnt=5; CycleCnt equals RUN cycles; both clear on next Start.
